// File: rtl/e203_exu_longp_cmt_buf.sv
// Long-pipe commit buffer: captures out-of-order LSU/MULDIV completions by OITF tag
// and releases them in OITF order to write-back, exception commit, or silent retire.
module e203_exu_longp_cmt_buf #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned PTR_W   = 1,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               lsu_rsp_valid,
    output logic               lsu_rsp_ready,
    input  logic [PTR_W-1:0]   lsu_rsp_itag,
    input  logic [XLEN-1:0]    lsu_rsp_wdat,
    input  logic               lsu_rsp_err,

    input  logic               mdv_rsp_valid,
    output logic               mdv_rsp_ready,
    input  logic [PTR_W-1:0]   mdv_rsp_itag,
    input  logic [XLEN-1:0]    mdv_rsp_wdat,

    input  logic               oitf_empty,
    input  logic [PTR_W-1:0]   oitf_ret_ptr,
    input  logic [RFIDX_W-1:0] oitf_ret_rdidx,
    input  logic               oitf_ret_rdwen,
    input  logic               oitf_ret_rdfpu,
    output logic               oitf_ret_ena,

    output logic               longp_wbck_o_valid,
    input  logic               longp_wbck_o_ready,
    output logic [XLEN-1:0]    longp_wbck_o_wdat,
    output logic [4:0]         longp_wbck_o_flags,
    output logic [RFIDX_W-1:0] longp_wbck_o_rdidx,
    output logic               longp_wbck_o_rdfpu,

    output logic               longp_excp_o_valid,
    input  logic               longp_excp_o_ready,
    output logic [PTR_W-1:0]   longp_excp_o_itag
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] err_q, err_d;
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];

    logic lsu_hs, mdv_hs;
    logic head_rdy, head_err, retire;

    always_comb begin
        lsu_rsp_ready = ~vld_q[lsu_rsp_itag];
        // Same-tag collision: LSU has priority, MULDIV waits.
        mdv_rsp_ready = ~vld_q[mdv_rsp_itag]
                        & ~(lsu_rsp_valid & (lsu_rsp_itag == mdv_rsp_itag));
        lsu_hs = lsu_rsp_valid & lsu_rsp_ready;
        mdv_hs = mdv_rsp_valid & mdv_rsp_ready;

        head_rdy = ~oitf_empty & vld_q[oitf_ret_ptr];
        head_err = err_q[oitf_ret_ptr];

        longp_excp_o_valid = head_rdy & head_err;
        longp_wbck_o_valid = head_rdy & ~head_err & oitf_ret_rdwen;

        // Payloads are zeroed while their valid is low so idle outputs read as 0.
        longp_excp_o_itag  = longp_excp_o_valid ? oitf_ret_ptr : '0;
        longp_wbck_o_wdat  = longp_wbck_o_valid ? data_q[oitf_ret_ptr] : '0;
        longp_wbck_o_rdidx = longp_wbck_o_valid ? oitf_ret_rdidx : '0;
        longp_wbck_o_rdfpu = longp_wbck_o_valid & oitf_ret_rdfpu;
        longp_wbck_o_flags = '0;

        retire = (longp_excp_o_valid & longp_excp_o_ready)
               | (longp_wbck_o_valid & longp_wbck_o_ready)
               | (head_rdy & ~head_err & ~oitf_ret_rdwen);
        oitf_ret_ena = retire;
    end

    always_comb begin
        vld_d = vld_q;
        err_d = err_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        if (retire) begin
            vld_d[oitf_ret_ptr] = 1'b0;
        end
        if (lsu_hs) begin
            vld_d[lsu_rsp_itag]  = 1'b1;
            err_d[lsu_rsp_itag]  = lsu_rsp_err;
            data_d[lsu_rsp_itag] = lsu_rsp_wdat;
        end
        if (mdv_hs) begin
            vld_d[mdv_rsp_itag]  = 1'b1;
            err_d[mdv_rsp_itag]  = 1'b0;
            data_d[mdv_rsp_itag] = mdv_rsp_wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

    // Slot data carries no reset; it is only observed behind a set vld bit.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule
